pacman_scan_gen: RTL and testbench
==================================

Name: pacman_scan_gen

Overview:
Produces the scan interface consumed by the pacman game renderer: VGA 800x600@60 timing (hsync/vsync/display_enabled) plus the 224x288 game-coordinate stream (sx, sy, game_pix_stb, frame_stb). The game window is upscaled by SCALE and centred on screen. The block sits between the top-level clocking and the game renderer, and its syncs drive the VGA pins. A sub-pixel counter scheme avoids dividers.

Parameters:
H_VISIBLE, 800, visible pixels per line
H_FRONT, 40, horizontal front porch
H_SYNC, 128, hsync width
H_BACK, 88, horizontal back porch (H_TOTAL = 1056)
V_VISIBLE, 600, visible lines
V_FRONT, 1, vertical front porch
V_SYNC, 4, vsync width
V_BACK, 23, vertical back porch (V_TOTAL = 628)
H_SYNC_POL, 1, hsync active level
V_SYNC_POL, 1, vsync active level
GAME_W, 224, game width in virtual pixels
GAME_H, 288, game height in virtual pixels
SCALE, 2, physical pixels per virtual pixel, both axes
GAME_X0, 176, first screen column of the game window
GAME_Y0, 12, first screen line of the game window
PIX_DIV, 1, clk cycles per screen pixel (1 means clk is the pixel clock)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
hsync  out  1  horizontal sync, H_SYNC_POL active
vsync  out  1  vertical sync, V_SYNC_POL active
vga_x  out  $clog2(H_TOTAL)  current screen column
vga_y  out  $clog2(V_TOTAL)  current screen line
display_enabled  out  1  vga_x < H_VISIBLE and vga_y < V_VISIBLE
game_active  out  1  current pixel lies inside the game window
sx  out  $clog2(GAME_W)  game column; 0 when game_active=0
sy  out  $clog2(GAME_H)  game row; 0 when game_active=0
game_pix_stb  out  1  one-clk strobe for each screen pixel inside the game window
game_new_pix  out  1  game_pix_stb restricted to the first physical pixel of each virtual pixel
frame_stb  out  1  one-clk strobe when position (0,0) is presented

Behaviour:
- pix_tick: a divider counts 0..PIX_DIV-1 and pix_tick is high when the divider is at PIX_DIV-1. With PIX_DIV=1, pix_tick is high every cycle. The divider resets to 0.
- Position registers advance only on pix_tick. vga_x wraps from H_TOTAL-1 to 0; vga_y increments on that wrap and itself wraps from V_TOTAL-1 to 0.
- Reset (async): the internal position is set to (H_TOTAL-1, V_TOTAL-1). Outputs reset to: vga_x=0, vga_y=0, hsync=vsync=inactive level, display_enabled=0, game_active=0, sx=sy=0, all strobes 0.
- The first pix_tick after reset release presents (0,0) with frame_stb=1.
- All outputs are registered and mutually aligned. They update in the clk cycle following pix_tick and describe the same position as vga_x/vga_y.
- hsync is active for vga_x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. 840..967. vsync is active for vga_y in [601, 605).
- Game window: vga_x in [GAME_X0, GAME_X0+GAME_W*SCALE) = 176..623 and vga_y in [GAME_Y0, GAME_Y0+GAME_H*SCALE) = 12..587.
- Horizontal sub-counter hsub: set to 0 with sx=0 at window entry. Each subsequent tick increments hsub; when hsub reaches SCALE-1 it wraps to 0 and sx increments.
- Vertical sub-counter vsub and sy follow the same rule, advanced once per line at the line wrap. Both are cleared at frame start.
- No division or multiplication by SCALE is permitted in the datapath; SCALE=1 must also work (hsub is always 0).
- game_pix_stb and frame_stb are high for exactly one clk per presented position (only the cycle after pix_tick), never for PIX_DIV cycles.
- game_new_pix = game_pix_stb and hsub==0.
- sx never exceeds GAME_W-1 and sy never exceeds GAME_H-1; leaving the window forces both to 0.
- Mid-frame reset: all outputs immediately take their reset values (asynchronous). The next frame restarts cleanly at (0,0) after release, with no partial-line artefacts.

Test Plan:
1. Reset, release, PIX_DIV=1 -> first cycle after release: vga_x=0, vga_y=0, frame_stb=1, display_enabled=1; frame_stb low next cycle; next frame_stb exactly 1056*628 = 663168 cycles later.
2. Sweep line 0 -> hsync active only for vga_x 840..967; display_enabled low for vga_x>=800; vga_y increments to 1 when vga_x wraps from 1055 to 0.
3. Line vga_y=12 -> game_active first at vga_x=176 with sx=0 and game_new_pix=1; vga_x=177 gives sx=0, game_new_pix=0; vga_x=178 gives sx=1; vga_x=623 gives sx=223; vga_x=624 gives game_active=0, sx=0.
4. Vertical: vga_y=11 -> no game_pix_stb anywhere on the line; vga_y=12,13 -> sy=0; vga_y=14 -> sy=1; vga_y=587 -> sy=287; vga_y=588 -> game_active=0. vsync active only on lines 601..604.
5. PIX_DIV=4 -> position advances every 4 clk; frame_stb and game_pix_stb are 1 clk wide; frame period is 4*663168 clk.
6. Assert rst at vga_x=300, vga_y=100 -> outputs immediately return to reset values; after release, (0,0) with frame_stb=1 on the first tick, and sx/sy sequencing matches test 3.

Source files
------------

// File: rtl/pacman_scan_gen.sv
// pacman_scan_gen: VGA 800x600@60 sync/position generator plus an upscaled, centred 224x288 game-coordinate stream
// ports: clk, rst (async, active-high) -> hsync, vsync, vga_x, vga_y, display_enabled,
//        game_active, sx, sy, game_pix_stb, game_new_pix, frame_stb (all registered, mutually aligned)
module pacman_scan_gen #(
    parameter int H_VISIBLE  = 800,
    parameter int H_FRONT    = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BACK     = 88,
    parameter int V_VISIBLE  = 600,
    parameter int V_FRONT    = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BACK     = 23,
    parameter int H_SYNC_POL = 1,
    parameter int V_SYNC_POL = 1,
    parameter int GAME_W     = 224,
    parameter int GAME_H     = 288,
    parameter int SCALE      = 2,
    parameter int GAME_X0    = 176,
    parameter int GAME_Y0    = 12,
    parameter int PIX_DIV    = 1,
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int XW        = $clog2(H_TOTAL),
    localparam int YW        = $clog2(V_TOTAL),
    localparam int SXW       = $clog2(GAME_W),
    localparam int SYW       = $clog2(GAME_H)
) (
    input  logic           clk,
    input  logic           rst,
    output logic           hsync,
    output logic           vsync,
    output logic [XW-1:0]  vga_x,
    output logic [YW-1:0]  vga_y,
    output logic           display_enabled,
    output logic           game_active,
    output logic [SXW-1:0] sx,
    output logic [SYW-1:0] sy,
    output logic           game_pix_stb,
    output logic           game_new_pix,
    output logic           frame_stb
);
    localparam int DW  = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
    localparam int SW  = SCALE > 1 ? $clog2(SCALE) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_VIS  = XW'(H_VISIBLE);
    localparam logic [XW-1:0] X_HS0  = XW'(H_VISIBLE + H_FRONT);
    localparam logic [XW-1:0] X_HS1  = XW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [XW-1:0] X_G0   = XW'(GAME_X0);
    localparam logic [XW-1:0] X_G1   = XW'(GAME_X0 + GAME_W * SCALE);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_VIS  = YW'(V_VISIBLE);
    localparam logic [YW-1:0] Y_VS0  = YW'(V_VISIBLE + V_FRONT);
    localparam logic [YW-1:0] Y_VS1  = YW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [YW-1:0] Y_G0   = YW'(GAME_Y0);
    localparam logic [YW-1:0] Y_G1   = YW'(GAME_Y0 + GAME_H * SCALE);
    localparam logic HS_ON = 1'(H_SYNC_POL);
    localparam logic VS_ON = 1'(V_SYNC_POL);

    logic [DW-1:0]  div;
    logic           pix_tick, line_wrap, in_x, in_y, in_win;
    logic [XW-1:0]  px, nx;
    logic [YW-1:0]  py, ny;
    logic [SW-1:0]  hsub, nhsub, vsub, nvsub;
    logic [SXW-1:0] nsx;
    logic [SYW-1:0] row, nrow;

    // px/py hold the last presented position; nx/ny is the one the next tick presents.
    // Reset parks px/py on the last position so the first tick lands on (0,0).
    always_comb begin
        pix_tick  = div == DIV_LAST;
        line_wrap = px == X_LAST;
        nx        = line_wrap ? '0 : px + XW'(1);
        ny        = line_wrap ? (py == Y_LAST ? '0 : py + YW'(1)) : py;
        in_x      = nx >= X_G0 && nx < X_G1;
        in_y      = ny >= Y_G0 && ny < Y_G1;
        in_win    = in_x && in_y;
        // row counters step once per line; they stay zero outside the window rows
        nvsub     = !line_wrap ? vsub : (!in_y || ny == Y_G0) ? '0 : vsub == SUB_LAST ? '0 : vsub + SW'(1);
        nrow      = !line_wrap ? row : (!in_y || ny == Y_G0) ? '0 : vsub == SUB_LAST ? row + SYW'(1) : row;
        nhsub     = (!in_win || nx == X_G0) ? '0 : hsub == SUB_LAST ? '0 : hsub + SW'(1);
        nsx       = (!in_win || nx == X_G0) ? '0 : hsub == SUB_LAST ? sx + SXW'(1) : sx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div             <= '0;
            px              <= X_LAST;
            py              <= Y_LAST;
            hsub            <= '0;
            vsub            <= '0;
            row             <= '0;
            vga_x           <= '0;
            vga_y           <= '0;
            hsync           <= !HS_ON;
            vsync           <= !VS_ON;
            display_enabled <= 1'b0;
            game_active     <= 1'b0;
            sx              <= '0;
            sy              <= '0;
            game_pix_stb    <= 1'b0;
            game_new_pix    <= 1'b0;
            frame_stb       <= 1'b0;
        end else begin
            div          <= pix_tick ? '0 : div + DW'(1);
            game_pix_stb <= pix_tick && in_win;
            game_new_pix <= pix_tick && in_win && nhsub == '0;
            frame_stb    <= pix_tick && nx == '0 && ny == '0;
            if (pix_tick) begin
                px              <= nx;
                py              <= ny;
                hsub            <= nhsub;
                vsub            <= nvsub;
                row             <= nrow;
                vga_x           <= nx;
                vga_y           <= ny;
                hsync           <= (nx >= X_HS0 && nx < X_HS1) ? HS_ON : !HS_ON;
                vsync           <= (ny >= Y_VS0 && ny < Y_VS1) ? VS_ON : !VS_ON;
                display_enabled <= nx < X_VIS && ny < Y_VIS;
                game_active     <= in_win;
                sx              <= nsx;
                sy              <= in_win ? nrow : '0;
            end
        end
    end
endmodule

// File: tb/tb_pacman_scan_gen.sv
// tb_pacman_scan_gen: directed checks of pacman_scan_gen at full 800x600 timing and a tiny PIX_DIV=4 timing
module tb_pacman_scan_gen;
    logic clk = 1'b0, rst = 1'b1, rst4 = 1'b1;
    always #5 clk = ~clk;

    logic        hsync, vsync, de, ga, gps, gnp, fs;
    logic [10:0] vga_x;
    logic [9:0]  vga_y;
    logic [7:0]  sx;
    logic [8:0]  sy;

    logic       hsync4, vsync4, de4, ga4, gps4, gnp4, fs4;
    logic [4:0] vga_x4;
    logic [3:0] vga_y4;
    logic [1:0] sx4, sy4;

    int n_vec = 0, n_bad = 0;

    pacman_scan_gen dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .vga_x(vga_x), .vga_y(vga_y),
        .display_enabled(de), .game_active(ga), .sx(sx), .sy(sy),
        .game_pix_stb(gps), .game_new_pix(gnp), .frame_stb(fs)
    );

    // 24x15 screen, 4x3 game at scale 2 placed at (4,2), one pixel every 4 clocks
    pacman_scan_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .GAME_W(4), .GAME_H(3), .SCALE(2), .GAME_X0(4), .GAME_Y0(2), .PIX_DIV(4)
    ) dut4 (
        .clk(clk), .rst(rst4), .hsync(hsync4), .vsync(vsync4), .vga_x(vga_x4), .vga_y(vga_y4),
        .display_enabled(de4), .game_active(ga4), .sx(sx4), .sy(sy4),
        .game_pix_stb(gps4), .game_new_pix(gnp4), .frame_stb(fs4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_big_rst(input string p);
        check({"rst_x", p}, vga_x, 0);
        check({"rst_y", p}, vga_y, 0);
        check({"rst_hs", p}, hsync, 0);
        check({"rst_vs", p}, vsync, 0);
        check({"rst_de", p}, de, 0);
        check({"rst_ga", p}, ga, 0);
        check({"rst_sx", p}, sx, 0);
        check({"rst_sy", p}, sy, 0);
        check({"rst_gps", p}, gps, 0);
        check({"rst_gnp", p}, gnp, 0);
        check({"rst_fs", p}, fs, 0);
    endtask

    task automatic check_small_rst(input string p);
        check({"s_rst_x", p}, vga_x4, 0);
        check({"s_rst_y", p}, vga_y4, 0);
        check({"s_rst_hs", p}, hsync4, 0);
        check({"s_rst_vs", p}, vsync4, 0);
        check({"s_rst_de", p}, de4, 0);
        check({"s_rst_ga", p}, ga4, 0);
        check({"s_rst_sx", p}, sx4, 0);
        check({"s_rst_sy", p}, sy4, 0);
        check({"s_rst_gps", p}, gps4, 0);
        check({"s_rst_gnp", p}, gnp4, 0);
        check({"s_rst_fs", p}, fs4, 0);
    endtask

    task automatic check_big(input int x, input int y);
        bit    w;
        string p;
        w = x >= 176 && x < 624 && y >= 12 && y < 588;
        p = $sformatf("@%0d,%0d", x, y);
        check({"x", p}, vga_x, x);
        check({"y", p}, vga_y, y);
        check({"hs", p}, hsync, x >= 840 && x < 968);
        check({"vs", p}, vsync, y >= 601 && y < 605);
        check({"de", p}, de, x < 800 && y < 600);
        check({"ga", p}, ga, w);
        check({"sx", p}, sx, w ? (x - 176) / 2 : 0);
        check({"sy", p}, sy, w ? (y - 12) / 2 : 0);
        check({"gps", p}, gps, w);
        check({"gnp", p}, gnp, w && (x - 176) % 2 == 0);
        check({"fs", p}, fs, x == 0 && y == 0);
    endtask

    task automatic check_small(input int idx, input bit stb);
        int    x, y;
        bit    w;
        string p;
        x = idx % 24;
        y = idx / 24;
        w = x >= 4 && x < 12 && y >= 2 && y < 8;
        p = $sformatf("@%0d,%0d/%0d", x, y, stb);
        check({"s_x", p}, vga_x4, x);
        check({"s_y", p}, vga_y4, y);
        check({"s_hs", p}, hsync4, x >= 18 && x < 21);
        check({"s_vs", p}, vsync4, y >= 11 && y < 13);
        check({"s_de", p}, de4, x < 16 && y < 10);
        check({"s_ga", p}, ga4, w);
        check({"s_sx", p}, sx4, w ? (x - 4) / 2 : 0);
        check({"s_sy", p}, sy4, w ? (y - 2) / 2 : 0);
        check({"s_gps", p}, gps4, stb && w);
        check({"s_gnp", p}, gnp4, stb && w && (x - 4) % 2 == 0);
        check({"s_fs", p}, fs4, stb && idx == 0);
    endtask

    // rst must have just been released after a negedge; the next negedge shows (0,0)
    task automatic sweep_big(input int lines);
        for (int t = 0; t < lines * 1056; t++) begin
            @(negedge clk);
            check_big(t % 1056, t / 1056);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_big_rst("@init");
        check_small_rst("@init");
        rst4 = 1'b0;
        // two full small frames: a tick lands on every 4th clock, the strobes last one clock
        for (int k = 1; k <= 2 * 1440 + 8; k++) begin
            @(negedge clk);
            if (k < 4) check_small_rst($sformatf("@k%0d", k));
            else check_small((k / 4 - 1) % 360, k % 4 == 0);
        end
        rst = 1'b0;
        sweep_big(16);
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            check_big(i, 16);
        end
        #2 rst = 1'b1;
        #1 check_big_rst("@async");
        @(negedge clk);
        check_big_rst("@held");
        rst = 1'b0;
        sweep_big(15);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
